// File: rtl/ysyx_24090018_lsu.sv
// Load/store unit: accepts one EXU result at a time, performs at most one memory
// access over a valid/ready request channel plus a response strobe, and hands the
// result to the WBU. FSM: IDLE -> (REQ -> WAIT ->) DONE -> IDLE.
// Optional feature macro: YSYX_24090018_MISALIGN_CHECK_EN adds misalign_o and
// completes misaligned half/word accesses without touching the bus.
module ysyx_24090018_lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic [2:0]            in_funct3,
    input  logic [DATA_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    input  logic [4:0]            in_rd,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [3:0]            mem_req_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_rdata,
    output logic [4:0]            out_rd,
    output logic                  out_wen
`ifdef YSYX_24090018_MISALIGN_CHECK_EN
    ,
    output logic                  misalign_o
`endif
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    state_e state_q, state_d;

    logic                  is_load_q;
    logic                  is_store_q;
    logic [2:0]            funct3_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [4:0]            rd_q;
    logic                  wen_q;

    logic                  accept;
    logic                  in_mem;
    logic                  skip_mem;
    logic [1:0]            off;
    logic [1:0]            acc_size;
    logic [3:0]            st_mask;
    logic [DATA_WIDTH-1:0] st_data;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] ld_data;

    // Access size: 0 byte, 1 half, 2 word. Unlisted encodings fall back to word.
    function automatic logic [1:0] size_of(input logic is_load, input logic [2:0] f3);
        if (f3 == 3'b000 || (is_load && f3 == 3'b100)) return 2'd0;
        if (f3 == 3'b001 || (is_load && f3 == 3'b101)) return 2'd1;
        return 2'd2;
    endfunction

    assign accept = in_valid && in_ready;
    assign in_mem = in_is_load || in_is_store;

`ifdef YSYX_24090018_MISALIGN_CHECK_EN
    logic [1:0] in_size;
    logic       misalign_q;

    // Detect misaligned half/word accesses at accept time so they bypass the bus.
    always_comb begin
        in_size  = size_of(in_is_load, in_funct3);
        skip_mem = in_mem && ((in_size == 2'd1 && in_addr[0]) ||
                              (in_size == 2'd2 && in_addr[1:0] != 2'b00));
    end

    // Misalign flag is captured with the transaction and shown only in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else if (accept) begin
            misalign_q <= skip_mem;
        end
    end

    assign misalign_o = misalign_q && (state_q == StDone);
`else
    assign skip_mem = 1'b0;
`endif

    // Byte-lane steering for stores and lane extraction for loads.
    always_comb begin
        off      = addr_q[1:0];
        acc_size = size_of(is_load_q, funct3_q);
        shifted  = mem_resp_rdata >> {off, 3'b000};
        st_mask  = 4'b1111;
        st_data  = wdata_q;
        ld_data  = mem_resp_rdata;
        unique case (acc_size)
            2'd0: begin
                st_mask = 4'b0001 << off;
                st_data = {4{wdata_q[7:0]}};
                ld_data = funct3_q[2] ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                      : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            end
            2'd1: begin
                // Shift truncates at the word edge, so off=3 keeps only lane 3.
                st_mask = 4'b0011 << off;
                st_data = {2{wdata_q[15:0]}};
                ld_data = funct3_q[2] ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                      : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            end
            default: begin
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) state_d = (in_mem && !skip_mem) ? StReq : StDone;
            end
            StReq: begin
                if (mem_req_ready) state_d = StWait;
            end
            StWait: begin
                if (mem_resp_valid) state_d = StDone;
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Transaction fields captured on accept; load result captured on response.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            rd_q       <= 5'd0;
            wen_q      <= 1'b0;
        end else if (accept) begin
            is_load_q  <= in_is_load;
            is_store_q <= in_is_store;
            funct3_q   <= in_funct3;
            addr_q     <= in_addr;
            wdata_q    <= in_wdata;
            rdata_q    <= in_mem ? '0 : in_addr;
            rd_q       <= in_rd;
            wen_q      <= (in_rd != 5'd0) && !in_is_store && !skip_mem;
        end else if (state_q == StWait && mem_resp_valid && is_load_q) begin
            rdata_q    <= ld_data;
        end
    end

    // Request fields are driven only in REQ and read as zero otherwise.
    always_comb begin
        in_ready      = (state_q == StIdle);
        mem_req_valid = (state_q == StReq);
        mem_req_addr  = '0;
        mem_req_wen   = 1'b0;
        mem_req_wdata = '0;
        mem_req_wmask = 4'b0000;
        if (state_q == StReq) begin
            mem_req_addr = {addr_q[DATA_WIDTH-1:2], 2'b00};
            if (is_store_q) begin
                mem_req_wen   = 1'b1;
                mem_req_wdata = st_data;
                mem_req_wmask = st_mask;
            end
        end
        out_valid = (state_q == StDone);
        out_rdata = rdata_q;
        out_rd    = rd_q;
        out_wen   = wen_q && (state_q == StDone);
    end

endmodule

// File: doc/ysyx_24090018_lsu.md
YSYX_24090018_LSU -- requirements
Module: ysyx_24090018_LSU

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data/address width; only 32 supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  EXU result valid.
REQ-005 SHALL have port in_ready  output  1  LSU can accept; high only in IDLE.
REQ-006 SHALL have port in_is_load / in_is_store  input  1 each  op class; both low = non-memory op.
REQ-007 SHALL have port in_funct3  input  3  access size/sign (LB 000, LH 001, LW 010, LBU 100, LHU 101, SB 000, SH 001, SW 010).
REQ-008 SHALL have port in_addr  input  32  EXU rf_wdata (effective address or ALU result).
REQ-009 SHALL have port in_wdata  input  32  store data (rs2); in_rd  input  5  destination register.
REQ-010 SHALL have ports mem_req_valid out 1, mem_req_ready in 1, mem_req_addr out 32 (word-aligned), mem_req_wen out 1, mem_req_wdata out 32, mem_req_wmask out 4.
REQ-011 SHALL have ports mem_resp_valid in 1, mem_resp_rdata in 32.
REQ-012 SHALL have ports out_valid out 1, out_ready in 1, out_rdata out 32, out_rd out 5, out_wen out 1 (to WBU).

Function
REQ-013 SHALL implement FSM IDLE, REQ, WAIT, DONE; input fields registered on in_valid && in_ready.
REQ-014 IDLE: on accept of load/store -> REQ; of non-memory op -> DONE with out_rdata=in_addr, out_wen=(in_rd!=0); latency 1 cycle.
REQ-015 REQ: mem_req_valid=1, fields held stable until mem_req_ready; on handshake -> WAIT.
REQ-016 WAIT: on mem_resp_valid -> DONE, capturing rdata for loads; stores ignore rdata; out_wen=0 for stores.
REQ-017 DONE: out_valid=1, outputs stable until out_ready; on handshake -> IDLE; in_ready low in DONE (no overlap).
REQ-018 mem_req_addr SHALL be {addr[31:2],2'b00}; off=addr[1:0].
REQ-019 Store mask: SB 4'b0001<<off, SH 4'b0011<<off, SW 4'b1111; wdata replicated: SB byte x4, SH half x2, SW as-is.
REQ-020 Load extract: byte/half selected by off, sign-extended for LB/LH, zero-extended for LBU/LHU; LW full word.
REQ-021 Load to rd=0 SHALL complete the bus access but drive out_wen=0.
REQ-022 mem_resp_valid outside WAIT SHALL be ignored; simultaneous mem_req_ready and mem_resp_valid in REQ: only req handshake counts.
REQ-023 Unlisted funct3 SHALL be treated as word access.

Reset
REQ-024 rst SHALL force IDLE; out_valid, mem_req_valid, out_wen, out_rdata, out_rd, mem_req_* outputs = 0; in_ready=1 first cycle after reset.
REQ-025 rst mid-transaction SHALL abandon it; responses arriving afterwards SHALL be ignored.

Configuration
REQ-026 Macro YSYX_24090018_MISALIGN_CHECK_EN defined: output misalign_o (1 bit) added; LH/LHU/SH with off[0]=1, or LW/SW with off!=0, SHALL skip REQ/WAIT, go IDLE->DONE, out_wen=0, misalign_o=1 while in DONE.
REQ-027 Macro undefined: no misalign_o port; misaligned half at off=3 uses mask 4'b1000 (shifted bits truncated), load takes byte 3 only, sign/zero-extended from a half with upper byte 0.

Verification
REQ-028 LW addr 0x80000004, mem_req_ready same cycle, resp 0xDEADBEEF next cycle -> mem_req_addr 0x80000004, out_rdata 0xDEADBEEF, out_wen=1, out_valid 3 cycles after accept.
REQ-029 LB addr 0x80000003, resp 0x80FF7F01 -> out_rdata 0xFFFFFF80; LBU same -> 0x00000080.
REQ-030 SH addr 0x80000002, wdata 0x1234ABCD -> wmask 4'b1100, mem_req_wdata 0xABCDABCD, mem_req_wen=1, out_wen=0.
REQ-031 Non-memory op in_addr 0x00000042, rd=5 -> out_valid next cycle, out_rdata 0x42, no mem_req_valid; out_ready held low 3 cycles -> outputs stable, in_ready low.
REQ-032 rst asserted in WAIT, then stray mem_resp_valid -> state IDLE, out_valid stays 0; with macro, LW addr 0x80000002 -> misalign_o=1, no mem_req_valid.
